// File: rtl/fl_mark_gen_if.sv
// fl_mark_gen_if: mark/queue/statistics bundle between fl_mark_gen (master) and its users (slave)
//   mark_o, mark_next_i        : mark value to the marker and its consume pulse
//   cfg_mode_i, cfg_step_i     : 0 = counter / 1 = queue, counter increment
//   wr_data_i, wr_en_i, wr_full_o : queue write port
//   cnt_clr_i, mark_cnt_o, underflow_cnt_o : statistics
interface fl_mark_gen_if #(parameter int MARK_SIZE = 4);
  logic [MARK_SIZE*8-1:0] mark_o;
  logic                   mark_next_i;
  logic                   cfg_mode_i;
  logic [7:0]             cfg_step_i;
  logic [MARK_SIZE*8-1:0] wr_data_i;
  logic                   wr_en_i;
  logic                   wr_full_o;
  logic                   cnt_clr_i;
  logic [31:0]            mark_cnt_o;
  logic [15:0]            underflow_cnt_o;
  modport master (
    output mark_o, wr_full_o, mark_cnt_o, underflow_cnt_o,
    input  mark_next_i, cfg_mode_i, cfg_step_i, wr_data_i, wr_en_i, cnt_clr_i
  );
  modport slave (
    input  mark_o, wr_full_o, mark_cnt_o, underflow_cnt_o,
    output mark_next_i, cfg_mode_i, cfg_step_i, wr_data_i, wr_en_i, cnt_clr_i
  );
endinterface

// File: rtl/fl_mark_gen.sv
// fl_mark_gen: registered mark source from a step counter or a write queue, with consume/underflow stats
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fl_mark_gen_if master (mark output, mark_next, config, queue write, statistics)
module fl_mark_gen #(
  parameter int                     MARK_SIZE    = 4,
  parameter int                     FIFO_DEPTH   = 8,
  parameter logic [MARK_SIZE*8-1:0] SEQ_INIT     = '0,
  parameter logic [MARK_SIZE*8-1:0] DEFAULT_MARK = '1
) (
  input logic clk,
  input logic rst_n,
  fl_mark_gen_if.master bus
);
  localparam int MW = MARK_SIZE * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  typedef enum logic {COUNT, QUEUE} state_t;
  state_t         state_q, state_d;
  logic [MW-1:0]  seq_q, seq_d, mark_q, mark_d, head_word;
  logic [MW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]  occ_q, occ_d;
  logic [31:0]    mcnt_q, mcnt_d;
  logic [15:0]    ucnt_q, ucnt_d;
  logic           in_queue, empty, full, pop, push, under;
  always_comb begin
    in_queue = state_q == QUEUE;
    empty    = occ_q == '0;
    full     = occ_q == OW'(FIFO_DEPTH);
    pop      = in_queue && bus.mark_next_i && !empty;
    under    = in_queue && bus.mark_next_i && empty;
    push     = bus.wr_en_i && (!full || pop);
    // mode switches only take effect in a cycle without a consume
    state_d  = bus.mark_next_i ? state_q : (bus.cfg_mode_i ? QUEUE : COUNT);
    seq_d    = (!in_queue && bus.mark_next_i) ? seq_q + MW'(bus.cfg_step_i) : seq_q;
    head_d   = pop ? head_q + AW'(1) : head_q;
    tail_d   = push ? tail_q + AW'(1) : tail_q;
    occ_d    = occ_q + OW'(push) - OW'(pop);
    // the word written this cycle is the new head when it lands on the new head slot
    head_word = (push && tail_q == head_d) ? bus.wr_data_i : mem_q[head_d];
    mark_d   = state_d == COUNT ? seq_d : (occ_d == '0 ? DEFAULT_MARK : head_word);
    mcnt_d   = bus.cnt_clr_i ? '0 : mcnt_q + 32'(bus.mark_next_i);
    ucnt_d   = bus.cnt_clr_i ? '0 : (under && ucnt_q != '1) ? ucnt_q + 16'd1 : ucnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COUNT;
      seq_q   <= SEQ_INIT;
      mark_q  <= SEQ_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      mcnt_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      mark_q  <= mark_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      mcnt_q  <= mcnt_d;
      ucnt_q  <= ucnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.wr_data_i;
  end
  assign bus.mark_o          = mark_q;
  assign bus.wr_full_o       = full;
  assign bus.mark_cnt_o      = mcnt_q;
  assign bus.underflow_cnt_o = ucnt_q;
endmodule

// File: tb/tb_fl_mark_gen.sv
// tb_fl_mark_gen: directed table-driven check of fl_mark_gen plus multi-cycle corner sequences
module tb_fl_mark_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  fl_mark_gen_if #(.MARK_SIZE(4)) ba ();
  fl_mark_gen_if #(.MARK_SIZE(1)) bb ();
  fl_mark_gen #(.MARK_SIZE(4), .FIFO_DEPTH(8), .SEQ_INIT(32'h0), .DEFAULT_MARK(32'hFFFF_FFFF))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ba.master));
  fl_mark_gen #(.MARK_SIZE(1), .FIFO_DEPTH(2), .SEQ_INIT(8'hFE), .DEFAULT_MARK(8'hFF))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bb.master));
  typedef struct {
    logic        mn, mode, wr, clr;
    logic [31:0] wd, mark;
    logic        full;
    logic [31:0] cnt;
    logic [15:0] uf;
  } vec_t;
  vec_t vq[$];
  localparam logic [31:0] DM = 32'hFFFF_FFFF;
  function automatic void add(input logic mn, mode, wr, input logic [31:0] wd, input logic clr,
                              input logic [31:0] mark, input logic full, input logic [31:0] cnt,
                              input logic [15:0] uf);
    vq.push_back('{mn: mn, mode: mode, wr: wr, clr: clr, wd: wd, mark: mark, full: full, cnt: cnt, uf: uf});
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic mn, mode, wr, input logic [31:0] wd, input logic clr);
    ba.mark_next_i = mn;
    ba.cfg_mode_i  = mode;
    ba.wr_en_i     = wr;
    ba.wr_data_i   = wd;
    ba.cnt_clr_i   = clr;
  endtask
  initial begin
    logic [31:0] drain [9];
    drain = '{32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h200, DM, DM};
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    ba.cfg_step_i = 8'd1;
    bb.mark_next_i = 0; bb.cfg_mode_i = 0; bb.cfg_step_i = 8'd3;
    bb.wr_data_i = '0; bb.wr_en_i = 0; bb.cnt_clr_i = 0;
    repeat (2) tick;
    chk("rst_mark", ba.mark_o, 32'h0);
    chk("rst_full", 32'(ba.wr_full_o), 32'h0);
    chk("rst_cnt", ba.mark_cnt_o, 32'h0);
    chk("rst_uf", 32'(ba.underflow_cnt_o), 32'h0);
    chk("b_rst_mark", 32'(bb.mark_o), 32'hFE);
    rst_n = 1'b1;
    tick;
    bb.mark_next_i = 1;
    tick;
    bb.mark_next_i = 0;
    chk("b_wrap_mark", 32'(bb.mark_o), 32'h01);
    tick;
    chk("b_hold_mark", 32'(bb.mark_o), 32'h01);
    chk("b_cnt", bb.mark_cnt_o, 32'd1);
    for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 0, 32'(i), 0, 32'(i), 0);
    add(0, 0, 0, 0,     0, 32'h5,  0, 5,  0);
    add(0, 0, 1, 32'hA, 0, 32'h5,  0, 5,  0);
    add(0, 0, 1, 32'hB, 0, 32'h5,  0, 5,  0);
    add(0, 0, 1, 32'hC, 0, 32'h5,  0, 5,  0);
    add(0, 1, 0, 0,     0, 32'hA,  0, 5,  0);
    add(1, 1, 0, 0,     0, 32'hB,  0, 6,  0);
    add(1, 1, 0, 0,     0, 32'hC,  0, 7,  0);
    add(1, 1, 0, 0,     0, DM,     0, 8,  0);
    add(1, 1, 0, 0,     0, DM,     0, 9,  1);
    add(0, 1, 1, 32'h11, 0, 32'h11, 0, 9, 1);
    add(1, 1, 1, 32'h22, 0, 32'h22, 0, 10, 1);
    add(1, 1, 0, 0,     0, DM,     0, 11, 1);
    add(1, 1, 1, 32'h44, 0, 32'h44, 0, 12, 2);
    add(1, 1, 0, 0,     0, DM,     0, 13, 2);
    add(1, 1, 0, 0,     1, DM,     0, 0,  0);
    foreach (vq[i]) begin
      drive(vq[i].mn, vq[i].mode, vq[i].wr, vq[i].wd, vq[i].clr);
      tick;
      chk($sformatf("v%0d_mark", i), ba.mark_o, vq[i].mark);
      chk($sformatf("v%0d_full", i), 32'(ba.wr_full_o), 32'(vq[i].full));
      chk($sformatf("v%0d_cnt", i), ba.mark_cnt_o, vq[i].cnt);
      chk($sformatf("v%0d_uf", i), 32'(ba.underflow_cnt_o), 32'(vq[i].uf));
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 32'h100 + 32'(i), 0);
      tick;
      chk($sformatf("fill%0d_full", i), 32'(ba.wr_full_o), 32'(i == 7));
      chk($sformatf("fill%0d_mark", i), ba.mark_o, 32'h100);
    end
    drive(0, 1, 1, 32'h1FF, 0);
    tick;
    chk("drop_full", 32'(ba.wr_full_o), 32'h1);
    chk("drop_mark", ba.mark_o, 32'h100);
    drive(1, 1, 1, 32'h200, 0);
    tick;
    chk("pushpop_full", 32'(ba.wr_full_o), 32'h1);
    chk("pushpop_mark", ba.mark_o, 32'h101);
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 0, 0, 0);
      tick;
      chk($sformatf("drain%0d_mark", i), ba.mark_o, drain[i]);
      if (i == 0) chk("drain0_full", 32'(ba.wr_full_o), 32'h0);
    end
    chk("drain_uf", 32'(ba.underflow_cnt_o), 32'd1);
    chk("drain_cnt", ba.mark_cnt_o, 32'd10);
    drive(1, 0, 0, 0, 0);
    tick;
    chk("defer_q_mark", ba.mark_o, DM);
    chk("defer_q_uf", 32'(ba.underflow_cnt_o), 32'd2);
    drive(0, 0, 0, 0, 0);
    tick;
    chk("resume_seq", ba.mark_o, 32'h5);
    drive(1, 0, 0, 0, 0);
    tick;
    chk("count_after_resume", ba.mark_o, 32'h6);
    drive(0, 0, 1, 32'h55, 0);
    tick;
    chk("write_in_count", ba.mark_o, 32'h6);
    drive(1, 1, 0, 0, 0);
    tick;
    chk("defer_c_mark", ba.mark_o, 32'h7);
    drive(0, 1, 0, 0, 0);
    tick;
    chk("switch_q_mark", ba.mark_o, 32'h55);
    drive(0, 0, 0, 0, 0);
    tick;
    chk("back_count_mark", ba.mark_o, 32'h7);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h66 + 32'(i), 0);
      tick;
    end
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mark", ba.mark_o, 32'h0);
    chk("async_rst_full", 32'(ba.wr_full_o), 32'h0);
    chk("async_rst_cnt", ba.mark_cnt_o, 32'h0);
    tick;
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0);
    tick;
    chk("post_rst_empty", ba.mark_o, DM);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
